// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator unit: op codes, flag bit positions
// and the width of one shadow-stack entry.
package acc_pkg;

   typedef enum logic [3:0] {
      OP_NOP   = 4'd0,
      OP_LOAD  = 4'd1,
      OP_ADD   = 4'd2,
      OP_ADC   = 4'd3,
      OP_SUB   = 4'd4,
      OP_AND   = 4'd5,
      OP_OR    = 4'd6,
      OP_XOR   = 4'd7,
      OP_SHL   = 4'd8,
      OP_SHR   = 4'd9,
      OP_ASR   = 4'd10,
      OP_INC   = 4'd11,
      OP_DEC   = 4'd12,
      OP_CLR   = 4'd13,
      OP_RSV14 = 4'd14,
      OP_RSV15 = 4'd15
   } op_e;

   // Flag nibble layout is {C, Z, N, V}, matching the low bits of a stack entry.
   localparam int FLAG_C    = 3;
   localparam int FLAG_Z    = 2;
   localparam int FLAG_N    = 1;
   localparam int FLAG_V    = 0;
   localparam int FLAG_BITS = 4;

   // One stack entry holds the accumulator plus the flag nibble.
   function automatic int stack_entry_width(input int width);
      return width + FLAG_BITS;
   endfunction

endpackage

// File: rtl/acc_stack.sv
// LIFO shadow stack: storage, pointer, full/empty decode and sticky error.
module acc_stack
   import acc_pkg::*;
#(
   parameter int EW    = 12,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          push,
   input  logic          pop,
   input  logic          err_clr,
   input  logic [EW-1:0] wr_data,
   output logic [EW-1:0] rd_data,
   output logic          pop_ok,
   output logic          full,
   output logic          empty,
   output logic          err
);

   localparam int SPW  = $clog2(DEPTH + 1);
   localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [EW-1:0]   r_mem [0:DEPTH-1];
   logic [SPW-1:0]  r_sp;
   logic            r_err;
   logic            w_push_ok;
   logic            w_err_evt;
   logic [IDXW-1:0] w_wr_idx;
   logic [IDXW-1:0] w_rd_idx;

   assign full      = (r_sp == SPW'(DEPTH));
   assign empty     = (r_sp == '0);
   assign err       = r_err;
   assign w_push_ok = push & ~pop & ~full;
   assign pop_ok    = pop & ~push & ~empty;
   // Simultaneous push/pop is treated as a conflict: neither takes effect.
   assign w_err_evt = (push & pop) | (push & full) | (pop & empty);
   assign w_wr_idx  = IDXW'(r_sp);
   assign w_rd_idx  = IDXW'(r_sp - 1'b1);
   // Read is asynchronous so a pop restores the top entry on the same edge.
   assign rd_data   = r_mem[w_rd_idx];

   // Storage write; contents need no reset since sp marks valid entries.
   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[w_wr_idx] <= wr_data;
      end
   end

   // Pointer movement and sticky error (a new error beats err_clr).
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_sp  <= '0;
         r_err <= 1'b0;
      end else begin
         if (w_push_ok) begin
            r_sp <= r_sp + 1'b1;
         end else if (pop_ok) begin
            r_sp <= r_sp - 1'b1;
         end
         if (w_err_evt) begin
            r_err <= 1'b1;
         end else if (err_clr) begin
            r_err <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/acc_unit.sv
// Accumulator with in-place ALU ops, C/Z/N/V flags and a shadow stack.
module acc_unit
   import acc_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en_da,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] acc_in,
   input  logic             push,
   input  logic             pop,
   input  logic             err_clr,
   output logic [WIDTH-1:0] acc_out,
   output logic             flag_c,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_v,
   output logic             stk_full,
   output logic             stk_empty,
   output logic             stk_err
);

   localparam int EW  = stack_entry_width(WIDTH);
   localparam int MSB = WIDTH - 1;

   logic [WIDTH-1:0]     r_acc;
   logic [FLAG_BITS-1:0] r_flags;
   op_e                  w_op;
   logic [WIDTH:0]       w_sum;
   logic [WIDTH-1:0]     w_res;
   logic                 w_c;
   logic                 w_v;
   logic                 w_upd;
   logic [EW-1:0]        w_rd_data;
   logic                 w_pop_ok;

   assign w_op    = op_e'(op);
   assign acc_out = r_acc;
   assign flag_c  = r_flags[FLAG_C];
   assign flag_z  = r_flags[FLAG_Z];
   assign flag_n  = r_flags[FLAG_N];
   assign flag_v  = r_flags[FLAG_V];

   acc_stack #(
      .EW    (EW),
      .DEPTH (DEPTH)
   ) u_stack (
      .clk     (clk),
      .clr     (clr),
      .push    (push),
      .pop     (pop),
      .err_clr (err_clr),
      .wr_data ({r_acc, r_flags}),
      .rd_data (w_rd_data),
      .pop_ok  (w_pop_ok),
      .full    (stk_full),
      .empty   (stk_empty),
      .err     (stk_err)
   );

   // ALU: result plus next C/V; C and V default to their held values.
   always_comb begin
      w_sum = '0;
      w_res = r_acc;
      w_c   = r_flags[FLAG_C];
      w_v   = r_flags[FLAG_V];
      w_upd = 1'b1;
      case (w_op)
         OP_LOAD: w_res = acc_in;
         OP_ADD, OP_ADC: begin
            w_sum = {1'b0, r_acc} + {1'b0, acc_in}
                  + {{WIDTH{1'b0}}, (w_op == OP_ADC) & r_flags[FLAG_C]};
            w_res = w_sum[WIDTH-1:0];
            w_c   = w_sum[WIDTH];
            w_v   = (r_acc[MSB] == acc_in[MSB]) && (w_res[MSB] != r_acc[MSB]);
         end
         OP_SUB: begin
            w_sum = {1'b0, r_acc} - {1'b0, acc_in};
            w_res = w_sum[WIDTH-1:0];
            w_c   = w_sum[WIDTH];
            w_v   = (r_acc[MSB] != acc_in[MSB]) && (w_res[MSB] != r_acc[MSB]);
         end
         OP_AND: begin w_res = r_acc & acc_in; w_v = 1'b0; end
         OP_OR:  begin w_res = r_acc | acc_in; w_v = 1'b0; end
         OP_XOR: begin w_res = r_acc ^ acc_in; w_v = 1'b0; end
         OP_SHL: begin w_res = {r_acc[MSB-1:0], 1'b0};      w_c = r_acc[MSB]; w_v = 1'b0; end
         OP_SHR: begin w_res = {1'b0, r_acc[MSB:1]};        w_c = r_acc[0];   w_v = 1'b0; end
         OP_ASR: begin w_res = {r_acc[MSB], r_acc[MSB:1]};  w_c = r_acc[0];   w_v = 1'b0; end
         OP_INC: begin
            w_sum = {1'b0, r_acc} + 1'b1;
            w_res = w_sum[WIDTH-1:0];
            w_c   = w_sum[WIDTH];
            w_v   = ~r_acc[MSB] & w_res[MSB];
         end
         OP_DEC: begin
            w_sum = {1'b0, r_acc} - 1'b1;
            w_res = w_sum[WIDTH-1:0];
            w_c   = w_sum[WIDTH];
            w_v   = r_acc[MSB] & ~w_res[MSB];
         end
         OP_CLR:  w_res = '0;
         default: w_upd = 1'b0;
      endcase
   end

   // Accumulator and flags: an accepted pop overrides any op this cycle.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_acc   <= '0;
         r_flags <= '0;
      end else if (w_pop_ok) begin
         r_acc   <= w_rd_data[EW-1:FLAG_BITS];
         r_flags <= w_rd_data[FLAG_BITS-1:0];
      end else if (en_da && w_upd) begin
         r_acc            <= w_res;
         r_flags[FLAG_C]  <= w_c;
         r_flags[FLAG_Z]  <= (w_res == '0);
         r_flags[FLAG_N]  <= w_res[MSB];
         r_flags[FLAG_V]  <= w_v;
      end
   end

endmodule

// File: tb/tb_acc_unit.sv
// Directed bench for acc_unit (WIDTH=8, DEPTH=4). Observed state is packed as
// {acc[7:0], C, Z, N, V} so each expectation is a 12-bit hex value.
module tb_acc_unit;
   import acc_pkg::*;

   logic       clk = 1'b0;
   logic       clr = 1'b0;
   logic       en_da = 1'b0;
   logic [3:0] op = 4'd0;
   logic [7:0] acc_in = 8'h00;
   logic       push = 1'b0;
   logic       pop = 1'b0;
   logic       err_clr = 1'b0;
   logic [7:0] acc_out;
   logic       flag_c, flag_z, flag_n, flag_v;
   logic       stk_full, stk_empty, stk_err;
   logic [11:0] obs;
   logic [2:0]  stk;
   int errors = 0;
   int checks = 0;

   acc_unit #(.WIDTH(8), .DEPTH(4)) dut (
      .clk(clk), .clr(clr), .en_da(en_da), .op(op), .acc_in(acc_in),
      .push(push), .pop(pop), .err_clr(err_clr), .acc_out(acc_out),
      .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v),
      .stk_full(stk_full), .stk_empty(stk_empty), .stk_err(stk_err)
   );

   always #5 clk = ~clk;

   assign obs = {acc_out, flag_c, flag_z, flag_n, flag_v};
   assign stk = {stk_full, stk_empty, stk_err};

   // Apply one cycle of stimulus, sample 1 time unit after the edge, then idle.
   task automatic cyc(input logic e, input logic [3:0] o, input logic [7:0] d,
                      input logic pu, input logic po, input logic ec);
      en_da = e; op = o; acc_in = d; push = pu; pop = po; err_clr = ec;
      @(posedge clk);
      #1;
      en_da = 1'b0; op = 4'd0; acc_in = 8'h00; push = 1'b0; pop = 1'b0; err_clr = 1'b0;
      $display("cyc en=%b op=%0d in=%h push=%b pop=%b ec=%b -> acc=%h czNv=%b%b%b%b full=%b empty=%b err=%b",
               e, o, d, pu, po, ec, acc_out, flag_c, flag_z, flag_n, flag_v, stk_full, stk_empty, stk_err);
   endtask

   task automatic test_reset;
      #12;
      checks++; if (obs !== 12'h000) begin errors++; $display("FAIL rst_acc: got %h exp %h", obs, 12'h000); end
      checks++; if (stk !== 3'b010) begin errors++; $display("FAIL rst_stk: got %b exp %b", stk, 3'b010); end
      @(negedge clk); clr = 1'b1;
      @(posedge clk); #1;
      cyc(1'b1, OP_LOAD, 8'h5A, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, OP_NOP,  8'h00, 1'b1, 1'b0, 1'b0);
      checks++; if ({obs, stk} !== {12'h5A0, 3'b000}) begin errors++; $display("FAIL pre_midrst: got %h/%b exp %h/%b", obs, stk, 12'h5A0, 3'b000); end
      // Drop reset between edges, with a LOAD pending, and look before the next edge.
      en_da = 1'b1; op = OP_LOAD; acc_in = 8'hEE;
      #2 clr = 1'b0;
      #1;
      checks++; if (obs !== 12'h000) begin errors++; $display("FAIL midrst_acc: got %h exp %h", obs, 12'h000); end
      checks++; if (stk !== 3'b010) begin errors++; $display("FAIL midrst_stk: got %b exp %b", stk, 3'b010); end
      en_da = 1'b0; op = 4'd0; acc_in = 8'h00;
      @(negedge clk); clr = 1'b1;
      @(posedge clk); #1;
      checks++; if (obs !== 12'h000) begin errors++; $display("FAIL post_rst: got %h exp %h", obs, 12'h000); end
   endtask

   task automatic test_overflow;
      cyc(1'b1, OP_LOAD, 8'h7F, 1'b0, 1'b0, 1'b0);
      checks++; if (obs !== 12'h7F0) begin errors++; $display("FAIL load7f: got %h exp %h", obs, 12'h7F0); end
      cyc(1'b1, OP_ADD, 8'h01, 1'b0, 1'b0, 1'b0);
      checks++; if (obs !== 12'h803) begin errors++; $display("FAIL add_ovf: got %h exp %h", obs, 12'h803); end
      cyc(1'b1, OP_ADD, 8'h80, 1'b0, 1'b0, 1'b0);
      checks++; if (obs !== 12'h00D) begin errors++; $display("FAIL add_carry: got %h exp %h", obs, 12'h00D); end
   endtask

   task automatic test_borrow;
      cyc(1'b1, OP_LOAD, 8'h00, 1'b0, 1'b0, 1'b0);
      checks++; if (obs !== 12'h00D) begin errors++; $display("FAIL load00_keepcv: got %h exp %h", obs, 12'h00D); end
      cyc(1'b1, OP_SUB, 8'h01, 1'b0, 1'b0, 1'b0);
      checks++; if (obs !== 12'hFFA) begin errors++; $display("FAIL sub_borrow: got %h exp %h", obs, 12'hFFA); end
      cyc(1'b1, OP_ADC, 8'h00, 1'b0, 1'b0, 1'b0);
      checks++; if (obs !== 12'h00C) begin errors++; $display("FAIL adc_cin: got %h exp %h", obs, 12'h00C); end
   endtask

   task automatic test_stack_limits;
      logic [7:0] vals [4];
      vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, OP_LOAD, vals[i], 1'b0, 1'b0, 1'b0);
         cyc(1'b0, OP_NOP, 8'h00, 1'b1, 1'b0, 1'b0);
      end
      checks++; if (stk !== 3'b100) begin errors++; $display("FAIL stk_full: got %b exp %b", stk, 3'b100); end
      cyc(1'b1, OP_LOAD, 8'h55, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, OP_NOP, 8'h00, 1'b1, 1'b0, 1'b0);
      checks++; if ({obs, stk} !== {12'h558, 3'b101}) begin errors++; $display("FAIL push_full: got %h/%b exp %h/%b", obs, stk, 12'h558, 3'b101); end
      cyc(1'b0, OP_NOP, 8'h00, 1'b0, 1'b0, 1'b1);
      checks++; if (stk !== 3'b100) begin errors++; $display("FAIL errclr1: got %b exp %b", stk, 3'b100); end
      for (int i = 3; i >= 0; i--) begin
         cyc(1'b0, OP_NOP, 8'h00, 1'b0, 1'b1, 1'b0);
         checks++; if (obs !== {vals[i], 4'h8}) begin errors++; $display("FAIL pop%0d: got %h exp %h", i, obs, {vals[i], 4'h8}); end
      end
      checks++; if (stk !== 3'b010) begin errors++; $display("FAIL stk_empty: got %b exp %b", stk, 3'b010); end
      cyc(1'b0, OP_NOP, 8'h00, 1'b0, 1'b1, 1'b0);
      checks++; if ({obs, stk} !== {12'h118, 3'b011}) begin errors++; $display("FAIL pop_empty: got %h/%b exp %h/%b", obs, stk, 12'h118, 3'b011); end
      cyc(1'b0, OP_NOP, 8'h00, 1'b0, 1'b0, 1'b1);
      checks++; if (stk !== 3'b010) begin errors++; $display("FAIL errclr2: got %b exp %b", stk, 3'b010); end
      // Error and err_clr on the same cycle: the error wins.
      cyc(1'b0, OP_NOP, 8'h00, 1'b0, 1'b1, 1'b1);
      checks++; if (stk !== 3'b011) begin errors++; $display("FAIL err_setwins: got %b exp %b", stk, 3'b011); end
      cyc(1'b0, OP_NOP, 8'h00, 1'b0, 1'b0, 1'b1);
      checks++; if (stk !== 3'b010) begin errors++; $display("FAIL errclr3: got %b exp %b", stk, 3'b010); end
   endtask

   task automatic test_back_to_back;
      cyc(1'b1, OP_LOAD, 8'h10, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, OP_ADD, 8'h05, 1'b1, 1'b0, 1'b0);
      checks++; if ({obs, stk} !== {12'h150, 3'b000}) begin errors++; $display("FAIL push_add: got %h/%b exp %h/%b", obs, stk, 12'h150, 3'b000); end
      cyc(1'b0, OP_NOP, 8'h00, 1'b0, 1'b1, 1'b0);
      checks++; if ({obs, stk} !== {12'h108, 3'b010}) begin errors++; $display("FAIL pop_preadd: got %h/%b exp %h/%b", obs, stk, 12'h108, 3'b010); end
      cyc(1'b0, OP_NOP, 8'h00, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, OP_LOAD, 8'h77, 1'b0, 1'b0, 1'b0);
      checks++; if (obs !== 12'h778) begin errors++; $display("FAIL load77: got %h exp %h", obs, 12'h778); end
      cyc(1'b1, OP_LOAD, 8'h99, 1'b0, 1'b1, 1'b0);
      checks++; if ({obs, stk} !== {12'h108, 3'b010}) begin errors++; $display("FAIL pop_wins: got %h/%b exp %h/%b", obs, stk, 12'h108, 3'b010); end
      cyc(1'b0, OP_NOP, 8'h00, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, OP_ADD, 8'h01, 1'b1, 1'b1, 1'b0);
      checks++; if ({obs, stk} !== {12'h110, 3'b001}) begin errors++; $display("FAIL pushpop: got %h/%b exp %h/%b", obs, stk, 12'h110, 3'b001); end
      cyc(1'b0, OP_NOP, 8'h00, 1'b0, 1'b1, 1'b1);
      checks++; if ({obs, stk} !== {12'h108, 3'b010}) begin errors++; $display("FAIL pushpop_sp: got %h/%b exp %h/%b", obs, stk, 12'h108, 3'b010); end
   endtask

   task automatic test_shifts;
      cyc(1'b1, OP_LOAD, 8'h81, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, OP_SHR, 8'h00, 1'b0, 1'b0, 1'b0);
      checks++; if (obs !== 12'h408) begin errors++; $display("FAIL shr: got %h exp %h", obs, 12'h408); end
      cyc(1'b1, OP_LOAD, 8'h81, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, OP_ASR, 8'h00, 1'b0, 1'b0, 1'b0);
      checks++; if (obs !== 12'hC0A) begin errors++; $display("FAIL asr: got %h exp %h", obs, 12'hC0A); end
      cyc(1'b1, OP_LOAD, 8'h81, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, OP_SHL, 8'h00, 1'b0, 1'b0, 1'b0);
      checks++; if (obs !== 12'h028) begin errors++; $display("FAIL shl: got %h exp %h", obs, 12'h028); end
      cyc(1'b0, OP_LOAD, 8'hFF, 1'b0, 1'b0, 1'b0);
      checks++; if (obs !== 12'h028) begin errors++; $display("FAIL gated: got %h exp %h", obs, 12'h028); end
      cyc(1'b1, OP_LOAD, 8'h40, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, OP_SHL, 8'h00, 1'b0, 1'b0, 1'b0);
      checks++; if (obs !== 12'h802) begin errors++; $display("FAIL shl_c0: got %h exp %h", obs, 12'h802); end
   endtask

   task automatic test_logic_incdec;
      cyc(1'b1, OP_LOAD, 8'h0F, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, OP_AND, 8'hF0, 1'b0, 1'b0, 1'b0);
      checks++; if (obs !== 12'h004) begin errors++; $display("FAIL and: got %h exp %h", obs, 12'h004); end
      cyc(1'b1, OP_OR, 8'h3C, 1'b0, 1'b0, 1'b0);
      checks++; if (obs !== 12'h3C0) begin errors++; $display("FAIL or: got %h exp %h", obs, 12'h3C0); end
      cyc(1'b1, OP_XOR, 8'hFF, 1'b0, 1'b0, 1'b0);
      checks++; if (obs !== 12'hC32) begin errors++; $display("FAIL xor: got %h exp %h", obs, 12'hC32); end
      cyc(1'b1, OP_LOAD, 8'hFF, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, OP_INC, 8'h00, 1'b0, 1'b0, 1'b0);
      checks++; if (obs !== 12'h00C) begin errors++; $display("FAIL inc_wrap: got %h exp %h", obs, 12'h00C); end
      cyc(1'b1, OP_DEC, 8'h00, 1'b0, 1'b0, 1'b0);
      checks++; if (obs !== 12'hFFA) begin errors++; $display("FAIL dec_borrow: got %h exp %h", obs, 12'hFFA); end
      cyc(1'b1, OP_CLR, 8'h00, 1'b0, 1'b0, 1'b0);
      checks++; if (obs !== 12'h00C) begin errors++; $display("FAIL clr: got %h exp %h", obs, 12'h00C); end
      cyc(1'b1, OP_LOAD, 8'h7F, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, OP_INC, 8'h00, 1'b0, 1'b0, 1'b0);
      checks++; if (obs !== 12'h803) begin errors++; $display("FAIL inc_ovf: got %h exp %h", obs, 12'h803); end
      cyc(1'b1, OP_DEC, 8'h00, 1'b0, 1'b0, 1'b0);
      checks++; if (obs !== 12'h7F1) begin errors++; $display("FAIL dec_ovf: got %h exp %h", obs, 12'h7F1); end
      cyc(1'b1, 4'd14, 8'hAA, 1'b0, 1'b0, 1'b0);
      checks++; if (obs !== 12'h7F1) begin errors++; $display("FAIL op14_nop: got %h exp %h", obs, 12'h7F1); end
   endtask

   initial begin
      test_reset();
      test_overflow();
      test_borrow();
      test_stack_limits();
      test_back_to_back();
      test_shifts();
      test_logic_incdec();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/acc_unit.md
# acc_unit

Parametrised accumulator for the processor datapath: a WIDTH-bit accumulator register with a built-in ALU operation set, a C/Z/N/V status flag register, and a DEPTH-entry LIFO shadow stack. The stack saves and restores accumulator and flags for subroutine and interrupt entry. It replaces the plain load-only accumulator and adds in-place arithmetic, logic and shift operations without a separate ALU pass.

## Interface
Parameters:
- WIDTH, 8: accumulator and operand width; ≥ 2.
- DEPTH, 4: shadow stack entries; ≥ 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- clr  in  1  asynchronous, active-low reset.
- en_da  in  1  qualifies op; when 0, no accumulator or flag change.
- op  in  4  operation code; see Operation.
- acc_in  in  WIDTH  operand.
- push  in  1  save {acc_out, flags} to the stack.
- pop  in  1  restore {acc_out, flags} from the stack.
- err_clr  in  1  synchronous clear of stk_err.
- acc_out  out  WIDTH  accumulator; reset 0.
- flag_c, flag_z, flag_n, flag_v  out  1 each  status flags; reset 0.
- stk_full  out  1  stack holds DEPTH entries; reset 0.
- stk_empty  out  1  stack holds 0 entries; reset 1.
- stk_err  out  1  sticky overflow/underflow/conflict flag; reset 0.

## Operation
Op codes (applied only when en_da=1):
- 0 NOP.
- 1 LOAD: acc=acc_in.
- 2 ADD: acc=acc+acc_in.
- 3 ADC: acc=acc+acc_in+C.
- 4 SUB: acc=acc−acc_in.
- 5 AND.
- 6 OR.
- 7 XOR.
- 8 SHL.
- 9 SHR, logical.
- 10 ASR.
- 11 INC.
- 12 DEC.
- 13 CLR: acc=0.
- 14–15 NOP.

Arithmetic:
- Computed at WIDTH+1 bits; result truncated to WIDTH bits.
- C: carry out for ADD/ADC/INC; borrow (1 when unsigned acc < operand) for SUB/DEC.
- V: two's-complement overflow for ADD/ADC/SUB/INC/DEC.

Flags:
- Z and N are updated from the result by every non-NOP op.
- LOAD and CLR: C and V unchanged.
- AND, OR, XOR: C unchanged, V=0.
- SHL, SHR, ASR: C = bit shifted out, V=0.
- SHL and SHR shift in 0; ASR replicates the MSB.

Stack:
- Each entry is WIDTH+4 bits: {acc, C, Z, N, V}.
- Pointer sp ranges 0..DEPTH. stk_empty = (sp==0); stk_full = (sp==DEPTH).
- push alone, not full: write the pre-edge {acc, flags} at sp; sp+1.
- pop alone, not empty: acc and flags take entry sp−1; sp−1. Any op on the same cycle is ignored, because pop wins.
- push together with an op: push stores the pre-op value, and the op is applied normally.
- push when full, or pop when empty: no state change; stk_err=1.
- push and pop on the same cycle: no stack or pointer change, op still applied; stk_err=1.
- stk_err is cleared only by err_clr=1 or by clr. If an error and err_clr occur on the same cycle, stk_err=1 (set wins).

## Timing
- All outputs are registered. The result of an op, push or pop is visible on outputs one cycle after the sampling edge.
- No combinational path from inputs to outputs.
- clr low clears immediately, with no clock needed: acc_out=0, all flags 0, sp=0, stk_err=0. Stack RAM contents are don't-care.
- Reset asserted mid-sequence discards any pending op.
- Full throughput: one op and one stack action per cycle, back to back. A pop directly after a push returns the value just pushed.

## Structure
- Shared package acc_pkg holds:
  - the op code constants, with names matching the list above;
  - flag bit indices;
  - the stack entry width expression WIDTH+4.
- Sub-module acc_stack(WIDTH+4, DEPTH) holds the LIFO storage, pointer, full/empty and error detection. Its reset is the same asynchronous clr.
- The top level holds the ALU case statement, the flag update logic and the accumulator register.

## Test plan
Benches use WIDTH=8, DEPTH=4.
1. Reset mid-sequence: LOAD 0x5A, push, then drop clr between edges → acc_out=0x00, all flags 0, stk_empty=1, stk_err=0 before the next edge.
2. Overflow: LOAD 0x7F, then ADD 0x01 → acc=0x80, N=1, V=1, C=0, Z=0. Then ADD 0x80 → acc=0x00, C=1, Z=1, V=1.
3. Borrow: LOAD 0x00, then SUB 0x01 → acc=0xFF, C=1, N=1, V=0. Then ADC 0x00 with C=1 → acc=0x00, C=1, Z=1.
4. Stack limits:
   - Push 0x11, 0x22, 0x33, 0x44 → stk_full=1.
   - Fifth push → stk_err=1, no change to stack contents.
   - Four pops → acc reads 0x44, 0x33, 0x22, 0x11; then stk_empty=1.
   - Extra pop → acc stays 0x11.
   - err_clr → stk_err=0.
5. Simultaneous events:
   - acc=0x10; push+ADD 0x05 → acc=0x15. Then pop → acc=0x10 with the pre-ADD flags.
   - pop together with LOAD 0x99 → LOAD ignored.
   - push+pop on the same cycle → sp unchanged, stk_err=1.
6. Shifts and gating:
   - LOAD 0x81, SHR → 0x40, C=1.
   - LOAD 0x81, ASR → 0xC0, C=1, N=1.
   - SHL of 0x81 → 0x02, C=1.
   - en_da=0 with op=LOAD 0xFF → acc and flags unchanged.
